// File: rtl/ctrl_pkg.sv
// Shared types and opcode-class constants for the multi-cycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [1:0] OP_R     = 2'b00;
    localparam logic [1:0] OP_RI    = 2'b01;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_MEM   = 3'b100;
    localparam logic [2:0] OP_BR    = 3'b101;
    localparam logic [3:0] OP_JMP   = 4'b1110;
    localparam logic [5:0] OP_RET   = 6'b111100;

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_JMP   = 2'b01;
    localparam logic [1:0] PC_STACK = 2'b10;
    localparam logic [1:0] PC_BR    = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg2_read_source;
        logic       alu_src;
        logic       is_shift;
        logic       mem_or_alu;
        logic       update_z_c;
        logic       reg_write_signal;
        logic       mem_req;
        logic       mem_read_write;
        logic       stack_push;
        logic       stack_pop;
        logic [1:0] scode;
    } ctrl_t;

endpackage

// File: rtl/ctrl_stack_depth.sv
// Return-stack occupancy counter; saturates at 0 and STACK_DEPTH.
module ctrl_stack_depth
    import ctrl_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    output logic full,
    output logic empty
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    logic [DW-1:0] depth;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC(/MEM/WB) with registered
// Moore outputs, memory handshake, return-stack depth tracking and HALT.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned IW          = 19,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned ACODE_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IW-1:0]      instruction,
    input  logic               instr_valid,
    input  logic               zero,
    input  logic               carry,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg2_read_source,
    output logic               alu_src,
    output logic               is_shift,
    output logic               mem_or_alu,
    output logic               update_z_c,
    output logic               reg_write_signal,
    output logic               mem_req,
    output logic               mem_read_write,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [1:0]         scode,
    output logic [ACODE_W-1:0] acode,
    output logic               halted,
    output logic               stack_fault,
    output logic               busy
);

    state_t               state;
    logic [IW-1:0]        ir;
    logic                 z_l, c_l;
    ctrl_t                ctl, exec_c;
    logic [ACODE_W-1:0]   acode_r, exec_acode;
    logic                 exec_fault, br_taken, full, empty;
    state_t               exec_next;
    logic [5:0]           op;
    logic [1:0]           sub;

    assign op  = ir[IW-1 -: 6];
    assign sub = ir[IW-4 -: 2];

    ctrl_stack_depth #(.STACK_DEPTH(STACK_DEPTH)) u_depth (
        .clk   (clk),
        .rst   (rst),
        .push  (ctl.stack_push),
        .pop   (ctl.stack_pop),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        case (sub)
            2'b00:   br_taken = z_l;
            2'b01:   br_taken = !z_l;
            2'b10:   br_taken = c_l;
            default: br_taken = !c_l;
        endcase
    end

    // EXEC controls; IR and depth are stable from DECODE through EXEC.
    always_comb begin
        exec_c          = '0;
        exec_c.pc_write = 1'b1;
        exec_acode      = '0;
        exec_fault      = 1'b0;
        exec_next       = FETCH;
        if (op[5:4] == OP_R || op[5:4] == OP_RI) begin
            exec_c.update_z_c       = 1'b1;
            exec_c.reg_write_signal = 1'b1;
            exec_c.mem_or_alu       = 1'b1;
            exec_c.alu_src          = (op[5:4] == OP_RI);
            exec_acode              = ir[IW-3 -: ACODE_W];
        end else if (op[5:3] == OP_SHIFT) begin
            exec_c.is_shift         = 1'b1;
            exec_c.scode            = sub;
            exec_c.mem_or_alu       = 1'b1;
            exec_c.reg_write_signal = 1'b1;
            exec_c.update_z_c       = 1'b1;
        end else if (op[5:3] == OP_MEM) begin
            exec_c.pc_write         = 1'b0;
            exec_c.reg2_read_source = 1'b1;
            exec_c.alu_src          = 1'b1;
            exec_next               = MEM;
        end else if (op[5:3] == OP_BR) begin
            exec_c.pc_src = br_taken ? PC_BR : PC_INC;
        end else if (op[5:2] == OP_JMP) begin
            exec_c.pc_src = PC_JMP;
            if (ir[IW-5]) begin
                if (full) exec_fault = 1'b1;
                else      exec_c.stack_push = 1'b1;
            end
        end else if (op == OP_RET) begin
            exec_c.pc_src = PC_STACK;
            if (empty) exec_fault = 1'b1;
            else       exec_c.stack_pop = 1'b1;
        end
        if (exec_fault) begin
            exec_c    = '0;
            exec_next = HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            ir          <= '0;
            z_l         <= 1'b0;
            c_l         <= 1'b0;
            ctl         <= '0;
            acode_r     <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            stack_fault <= 1'b0;
        end else begin
            ctl     <= '0;
            acode_r <= '0;
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir           <= instruction;
                        z_l          <= zero;
                        c_l          <= carry;
                        ctl.ir_write <= 1'b1;
                        busy         <= 1'b1;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    if (&ir) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state   <= EXEC;
                        ctl     <= exec_c;
                        acode_r <= exec_acode;
                        if (exec_fault) stack_fault <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_next == MEM) begin
                        state              <= MEM;
                        ctl.mem_req        <= !sub[1];
                        ctl.mem_read_write <= (sub == 2'b01);
                    end else if (exec_next == HALT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state <= FETCH;
                        busy  <= 1'b0;
                    end
                end
                MEM: begin
                    if (sub[1] || mem_ready) begin
                        state        <= WB;
                        ctl.pc_write <= 1'b1;
                        if (sub == 2'b00) ctl.reg_write_signal <= 1'b1;
                    end else begin
                        ctl.mem_req        <= 1'b1;
                        ctl.mem_read_write <= (sub == 2'b01);
                    end
                end
                WB: begin
                    state <= FETCH;
                    busy  <= 1'b0;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign ir_write         = ctl.ir_write;
    assign pc_write         = ctl.pc_write;
    assign pc_src           = ctl.pc_src;
    assign reg2_read_source = ctl.reg2_read_source;
    assign alu_src          = ctl.alu_src;
    assign is_shift         = ctl.is_shift;
    assign mem_or_alu       = ctl.mem_or_alu;
    assign update_z_c       = ctl.update_z_c;
    assign reg_write_signal = ctl.reg_write_signal;
    assign mem_req          = ctl.mem_req;
    assign mem_read_write   = ctl.mem_read_write;
    assign stack_push       = ctl.stack_push;
    assign stack_pop        = ctl.stack_pop;
    assign scode            = ctl.scode;
    assign acode            = acode_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (IW=19, STACK_DEPTH=2).
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [18:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic        zero = 1'b0;
    logic        carry = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, reg2_read_source, alu_src, is_shift;
    logic        mem_or_alu, update_z_c, reg_write_signal, mem_req, mem_read_write;
    logic        stack_push, stack_pop, halted, stack_fault, busy;
    logic [1:0]  pc_src, scode;
    logic [2:0]  acode;

    int total = 0;
    int bad = 0;

    localparam logic [18:0] I_ADD   = 19'h08000;
    localparam logic [18:0] I_ADDI  = 19'h2C000;
    localparam logic [18:0] I_SHIFT = 19'h68000;
    localparam logic [18:0] I_LOAD  = 19'h40000;
    localparam logic [18:0] I_STORE = 19'h44000;
    localparam logic [18:0] I_BRNZ  = 19'h54000;
    localparam logic [18:0] I_JMP   = 19'h70000;
    localparam logic [18:0] I_JSB   = 19'h74000;
    localparam logic [18:0] I_RET   = 19'h78000;
    localparam logic [18:0] I_HALT  = 19'h7FFFF;

    multicycle_controller #(.IW(19), .STACK_DEPTH(2), .ACODE_W(3)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .zero(zero), .carry(carry), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg2_read_source(reg2_read_source), .alu_src(alu_src), .is_shift(is_shift),
        .mem_or_alu(mem_or_alu), .update_z_c(update_z_c), .reg_write_signal(reg_write_signal),
        .mem_req(mem_req), .mem_read_write(mem_read_write),
        .stack_push(stack_push), .stack_pop(stack_pop), .scode(scode), .acode(acode),
        .halted(halted), .stack_fault(stack_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents ins for one FETCH cycle; returns at the DECODE-cycle negedge.
    task automatic accept(input logic [18:0] ins, input logic z, input logic c);
        @(negedge clk);
        instruction = ins;
        zero = z;
        carry = c;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({ir_write, pc_write, mem_req, reg_write_signal, stack_push, stack_pop} !== 6'b0) begin bad++; $display("FAIL reset_ctrls got=%b exp=000000", {ir_write, pc_write, mem_req, reg_write_signal, stack_push, stack_pop}); end
        total++; if ({busy, halted, stack_fault, pc_src, acode} !== 8'b0) begin bad++; $display("FAIL reset_status got=%b exp=00000000", {busy, halted, stack_fault, pc_src, acode}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        mem_ready = 1'b1;
        accept(I_ADD, 1'b0, 1'b0);
        total++; if ({ir_write, busy, pc_write} !== 3'b110) begin bad++; $display("FAIL rtype_decode got=%b exp=110", {ir_write, busy, pc_write}); end
        @(negedge clk);
        total++; if ({reg_write_signal, update_z_c, mem_or_alu, pc_write, alu_src, mem_req} !== 6'b111100) begin bad++; $display("FAIL rtype_exec got=%b exp=111100", {reg_write_signal, update_z_c, mem_or_alu, pc_write, alu_src, mem_req}); end
        total++; if ({acode, pc_src, ir_write} !== 6'b010000) begin bad++; $display("FAIL rtype_acode got=%b exp=010000", {acode, pc_src, ir_write}); end
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({busy, pc_write, reg_write_signal} !== 3'b000) begin bad++; $display("FAIL rtype_fetch got=%b exp=000", {busy, pc_write, reg_write_signal}); end
    endtask

    task automatic test_ri_shift();
        accept(I_ADDI, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({alu_src, reg_write_signal, acode, is_shift} !== 6'b110110) begin bad++; $display("FAIL ri_exec got=%b exp=110110", {alu_src, reg_write_signal, acode, is_shift}); end
        accept(I_SHIFT, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({is_shift, scode, mem_or_alu, reg_write_signal, update_z_c, pc_write, acode} !== 10'b1101111000) begin bad++; $display("FAIL shift_exec got=%b exp=1101111000", {is_shift, scode, mem_or_alu, reg_write_signal, update_z_c, pc_write, acode}); end
    endtask

    task automatic test_load();
        int cnt = 0;
        bit seen_wb = 0;
        accept(I_LOAD, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({reg2_read_source, alu_src, pc_write, mem_req} !== 4'b1100) begin bad++; $display("FAIL load_exec got=%b exp=1100", {reg2_read_source, alu_src, pc_write, mem_req}); end
        for (int i = 0; i < 12 && !seen_wb; i++) begin
            @(negedge clk);
            if (mem_req) begin
                cnt++;
                total++; if (mem_read_write !== 1'b0) begin bad++; $display("FAIL load_rw got=%b exp=0", mem_read_write); end
                mem_ready = (cnt == 4);
            end else begin
                seen_wb = 1;
                mem_ready = 1'b0;
                total++; if ({reg_write_signal, mem_or_alu, pc_write, pc_src} !== 5'b10100) begin bad++; $display("FAIL load_wb got=%b exp=10100", {reg_write_signal, mem_or_alu, pc_write, pc_src}); end
            end
        end
        total++; if (cnt !== 4 || !seen_wb) begin bad++; $display("FAIL load_req_cycles got=%0d wb=%0d exp=4 wb=1", cnt, seen_wb); end
    endtask

    task automatic test_store();
        accept(I_STORE, 1'b0, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_exec_req got=%b exp=0", mem_req); end
        @(negedge clk);
        total++; if ({mem_req, mem_read_write} !== 2'b11) begin bad++; $display("FAIL store_mem got=%b exp=11", {mem_req, mem_read_write}); end
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({mem_req, reg_write_signal, pc_write, busy} !== 4'b0011) begin bad++; $display("FAIL store_wb got=%b exp=0011", {mem_req, reg_write_signal, pc_write, busy}); end
    endtask

    task automatic test_branch();
        accept(I_BRNZ, 1'b0, 1'b0);
        zero = 1'b1;
        @(negedge clk);
        total++; if ({pc_write, pc_src} !== 3'b111) begin bad++; $display("FAIL br_taken got=%b exp=111", {pc_write, pc_src}); end
        accept(I_BRNZ, 1'b1, 1'b0);
        zero = 1'b0;
        @(negedge clk);
        total++; if ({pc_write, pc_src} !== 3'b100) begin bad++; $display("FAIL br_not_taken got=%b exp=100", {pc_write, pc_src}); end
        accept(I_JMP, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({pc_write, pc_src, stack_push} !== 4'b1010) begin bad++; $display("FAIL jmp got=%b exp=1010", {pc_write, pc_src, stack_push}); end
    endtask

    task automatic test_stack_overflow();
        do_reset();
        for (int n = 0; n < 2; n++) begin
            accept(I_JSB, 1'b0, 1'b0);
            @(negedge clk);
            total++; if ({stack_push, pc_src, pc_write, stack_fault} !== 5'b10110) begin bad++; $display("FAIL jsb_%0d got=%b exp=10110", n, {stack_push, pc_src, pc_write, stack_fault}); end
        end
        accept(I_JSB, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({stack_push, pc_write, stack_fault} !== 3'b001) begin bad++; $display("FAIL jsb_overflow got=%b exp=001", {stack_push, pc_write, stack_fault}); end
        @(negedge clk);
        total++; if ({halted, busy, stack_fault} !== 3'b101) begin bad++; $display("FAIL jsb_halt got=%b exp=101", {halted, busy, stack_fault}); end
        instruction = I_ADD;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if ({halted, ir_write, busy, pc_write} !== 4'b1000) begin bad++; $display("FAIL halt_absorb_%0d got=%b exp=1000", k, {halted, ir_write, busy, pc_write}); end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_ret();
        do_reset();
        total++; if ({stack_fault, halted} !== 2'b00) begin bad++; $display("FAIL fault_cleared got=%b exp=00", {stack_fault, halted}); end
        accept(I_RET, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({stack_pop, pc_write, stack_fault} !== 3'b001) begin bad++; $display("FAIL ret_underflow got=%b exp=001", {stack_pop, pc_write, stack_fault}); end
        @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ret_halt got=%b exp=1", halted); end
        do_reset();
        accept(I_JSB, 1'b0, 1'b0);
        @(negedge clk);
        accept(I_RET, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({stack_pop, pc_src, pc_write, stack_fault} !== 5'b11010) begin bad++; $display("FAIL ret_ok got=%b exp=11010", {stack_pop, pc_src, pc_write, stack_fault}); end
    endtask

    task automatic test_halt();
        do_reset();
        accept(I_HALT, 1'b0, 1'b0);
        total++; if ({ir_write, halted} !== 2'b10) begin bad++; $display("FAIL halt_decode got=%b exp=10", {ir_write, halted}); end
        @(negedge clk);
        total++; if ({halted, busy, pc_write, stack_fault} !== 4'b1000) begin bad++; $display("FAIL halt_state got=%b exp=1000", {halted, busy, pc_write, stack_fault}); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        accept(I_LOAD, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midmem_req got=%b exp=1", mem_req); end
        rst = 1'b1;
        #1;
        total++; if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL midmem_async got=%b exp=00", {mem_req, busy}); end
        @(negedge clk);
        rst = 1'b0;
        accept(I_ADD, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({reg_write_signal, pc_write, mem_req} !== 3'b110) begin bad++; $display("FAIL midmem_recover got=%b exp=110", {reg_write_signal, pc_write, mem_req}); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ri_shift();
        test_load();
        test_store();
        test_branch();
        test_stack_overflow();
        test_ret();
        test_halt();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised, multi-cycle successor to the single-cycle instruction decoder.
- Sequences each instruction through FETCH/DECODE/EXEC, plus MEM/WB for memory ops, using an explicit state machine.
- Adds a valid/ready memory handshake, a return-stack depth tracker with fault detection, and a HALT state in place of a simulation stop.
- Sits between the instruction memory, the register file/ALU datapath, the data memory and the PC/stack unit.

Parameters:
- IW, 19, instruction width; opcode fields are always the top 6 bits [IW-1:IW-6]; IW >= 8.
- STACK_DEPTH, 8, return-stack entries tracked for jsb/ret.
- ACODE_W, 3, ALU operation code width; taken from [IW-3 -: ACODE_W].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  IW  instruction word from instruction memory.
- instr_valid  in  1  instruction word is valid this cycle.
- zero, carry  in  1 each  datapath flag register outputs.
- mem_ready  in  1  data memory has completed the access.
- ir_write  out  1  latch instruction into the IR (FETCH accept cycle).
- pc_write  out  1  commit the next PC selected by pc_src.
- pc_src  out  2  00 PC+1, 01 jump target, 10 stack top (ret), 11 branch target.
- reg2_read_source, alu_src, is_shift, mem_or_alu, update_z_c, reg_write_signal  out  1 each  datapath controls; decode is identical to the single-cycle controller.
- mem_req  out  1  data memory request.
- mem_read_write  out  1  0 = read, 1 = write.
- stack_push, stack_pop  out  1 each.
- scode  out  2  shift code.
- acode  out  ACODE_W  ALU operation code.
- halted  out  1  HALT state reached.
- stack_fault  out  1  sticky overflow/underflow flag.
- busy  out  1  high in every state except FETCH and HALT.

Behaviour:
- Reset: all outputs 0, state FETCH, depth counter 0, stack_fault 0.
- All outputs are registered (Moore on state plus the latched IR). Every control pulses for exactly one cycle unless noted.
- FETCH: wait for instr_valid.
  - On accept: ir_write=1 and the IR/flag latch captures instruction, zero and carry.
  - Next state: DECODE.
- DECODE:
  - All-ones instruction -> HALT.
  - Otherwise -> EXEC.
  - Branch condition is evaluated from the latched flags: sub 00 zero, 01 !zero, 10 carry, 11 !carry.
- EXEC, one cycle, then FETCH unless noted; pc_write=1 except for the memory class.
  - 00 R-type: update_z_c, reg_write_signal, mem_or_alu=1, acode from IR.
  - 01 R-immediate: same as R-type plus alu_src=1.
  - 110 shift: is_shift, scode, mem_or_alu, reg_write_signal, update_z_c.
  - 100 memory: reg2_read_source=1, alu_src=1, go to MEM; pc_write deferred to WB.
  - 101 branch: pc_src=11 if the condition is true, else 00.
  - 1110 jmp (bit14=0): pc_src=01.
  - 1110 jsb (bit14=1): pc_src=01 with stack_push=1, provided depth < STACK_DEPTH.
  - 111100 ret: pc_src=10 with stack_pop=1, provided depth > 0.
  - Undefined opcodes execute as NOP: pc_src=00, pc_write=1.
- Stack faults:
  - jsb with depth==STACK_DEPTH, or ret with depth==0: no push/pop, no pc_write, set stack_fault, go to HALT.
  - The depth counter never wraps.
- MEM:
  - mem_req=1 held, with mem_read_write=1 for store (sub 01), 0 for load (sub 00).
  - Stays in MEM until mem_ready; the cycle mem_ready is sampled high -> WB.
  - Sub 10/11: no request, straight to WB.
- WB:
  - Load: reg_write_signal=1, mem_or_alu=0.
  - All sub-codes: pc_write=1, pc_src=00, then FETCH.
- HALT: absorbing; halted=1; all other controls 0. Exit only via rst.
- Simultaneous events: mem_ready in a non-MEM state is ignored; instr_valid outside FETCH is ignored.
- Reset mid-operation (including mid-MEM): controls drop immediately (async); depth and fault are cleared.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - opcode class constants OP_R=2'b00, OP_RI=2'b01, OP_SHIFT=3'b110, OP_MEM=3'b100, OP_BR=3'b101, OP_JMP=4'b1110, OP_RET=6'b111100;
  - pc_src constants.
- Sub-module ctrl_stack_depth: up/down counter with full/empty outputs, reset to 0, parameter STACK_DEPTH.

Test Plan:
- R-type add (acode 010) with instr_valid=1 -> ir_write at cycle 0; reg_write_signal=1, update_z_c=1, acode=010, pc_write=1 in cycle 2; back in FETCH at cycle 3.
- Load with mem_ready delayed 3 cycles -> mem_req high for exactly 4 cycles with mem_read_write=0; WB has reg_write_signal=1, mem_or_alu=0, pc_write=1. Store with mem_ready immediate -> mem_read_write=1, no reg_write_signal.
- Branch sub 01 with latched zero=0 -> pc_src=11; repeat with zero=1 -> pc_src=00; flag changes after FETCH have no effect.
- STACK_DEPTH=2: jsb, jsb, jsb -> two stack_push pulses, then stack_fault=1, halted=1, no third push. After reset, ret -> stack_fault=1, no stack_pop.
- Instruction 19'h7FFFF -> halted=1 two cycles after accept; further instr_valid ignored. rst asserted mid-MEM -> mem_req=0 asynchronously, state FETCH.
